verdict_collector: RTL
======================

Name: verdict_collector

Overview:
- Captures the monitor's output streams (values plus activation flags) on every cycle where at least one output is active.
- Timestamps each capture with a free-running cycle counter and buffers the record in a FIFO.
- Drains records to a downstream consumer (logger, UART bridge, host DMA) over a valid/ready handshake.
- Sits directly after topEntity. It is the receiving end of the monitor's output interface, mirroring the stimulus side that drives the inputs.

Parameters:
- NUM_OUTPUTS, 2, number of monitor output streams
- DATA_WIDTH, 64, width of each output value (signed, passed through untouched)
- TS_WIDTH, 32, timestamp counter width
- DEPTH, 16, FIFO depth in records; must be a power of 2, ≥ 2
- CNT_WIDTH, 16, dropped-record counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global enable; when 0, no capture and timestamp frozen
- out_data  in  NUM_OUTPUTS*DATA_WIDTH  packed monitor outputs, stream i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_aktv  in  NUM_OUTPUTS  per-stream activation flags
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_timestamp  out  TS_WIDTH  cycle count at capture
- rec_aktv  out  NUM_OUTPUTS  captured activation mask
- rec_data  out  NUM_OUTPUTS*DATA_WIDTH  captured values
- fifo_level  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when any record is dropped
- dropped_count  out  CNT_WIDTH  saturating count of dropped records

Behaviour:
- Clock/reset: single clock `clk`. `rst` is synchronous and active-high, sampled at posedge clk.

- Reset values: rec_valid=0, fifo_level=0, overflow=0, dropped_count=0, timestamp counter=0, read/write pointers=0. rec_* data outputs=0.

- Timestamp counter:
  - Increments at each posedge with en=1 and rst=0.
  - Wraps modulo 2^TS_WIDTH with no flag.
  - The first enabled cycle after reset release captures timestamp 0.

- Capture condition: en=1 and (|out_aktv)=1 at a posedge. The record is {counter value at that edge, out_aktv, out_data}.
  - Inactive streams' values are stored as presented; no masking.
  - All-zero aktv is never stored.

- Write latency:
  - The record is written at the capture edge.
  - rec_valid rises after the next edge at the earliest: 1-cycle latency, no combinational bypass.

- Read handshake:
  - rec_valid = (level ≠ 0).
  - rec_* show the head entry and are stable while rec_valid=1 and rec_ready=0.
  - Pop occurs at a posedge with rec_valid=1 and rec_ready=1.
  - rec_ready is ignored when empty.
  - Draining is independent of en.

- FIFO state (level-based, no explicit FSM beyond EMPTY/PARTIAL/FULL):
  - EMPTY: level=0.
  - FULL: level=DEPTH.
  - Push only: level+1. Pop only: level−1. Both: level unchanged.
  - Pointers wrap modulo DEPTH.

- Full boundary:
  - Capture while full with no pop in the same cycle: the record is dropped.
  - On a drop, overflow←1 (sticky until rst) and dropped_count increments, saturating at 2^CNT_WIDTH−1.
  - Capture while full with a simultaneous pop: the push is accepted, level stays DEPTH, and there is no drop.

- Empty boundary: a push into an empty FIFO with rec_ready=1 has no effect on that cycle's handshake (rec_valid was 0). The record appears the following cycle.

- Reset mid-operation: rst wins over all activity in the same cycle.
  - All buffered records are discarded.
  - rec_valid=0 on the next cycle.
  - A capture in the reset cycle is lost.

- Ordering: records leave in strict capture order. Timestamps are non-decreasing modulo wrap.

Test Plan:
1. Single capture:
   - Stimulus: reset 2 cycles, en=1, rec_ready=0. At counter=500, drive aktv=2'b01, out_data stream0=42.
   - Required: rec_valid=1 one cycle later with timestamp=500, aktv=01, data0=42, fifo_level=1.
   - Then assert rec_ready: rec_valid drops next cycle, level=0.

2. Backpressure ordering:
   - Stimulus: rec_ready=0; captures at timestamps 10, 11, 15 with values 1, 2, 3; then rec_ready=1 continuously.
   - Required: records emerge as (10,1), (11,2), (15,3) on consecutive cycles. Head is held stable while ready=0.

3. Overflow (DEPTH=16, rec_ready=0):
   - Stimulus: 20 consecutive active cycles.
   - Required: level=16, overflow=1, dropped_count=4. Drained records carry the first 16 timestamps.

4. Full with simultaneous pop:
   - Stimulus: FIFO full, rec_ready=1, aktv=01 for 5 cycles.
   - Required: no drops, dropped_count unchanged, level stays 16.

5. Enable gating and wrap:
   - Stimulus: TS_WIDTH=4; en=0 for 3 cycles with aktv=11.
   - Required: no records and counter frozen.
   - Stimulus: en=1 until the counter reaches 15, capture; next-cycle capture.
   - Required: timestamps 15 then 0.

6. Reset mid-drain:
   - Stimulus: 5 records buffered, rec_ready=1, assert rst for 1 cycle during a pop.
   - Required: next cycle rec_valid=0, level=0, overflow=0, dropped_count=0, counter=0.

Source files
------------

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps every cycle in which at least one monitor
// output stream is active and buffers the record in a FIFO. Records drain to
// a downstream consumer over a valid/ready handshake. When the FIFO is full
// and nothing leaves in the same cycle, the record is dropped; a sticky flag
// and a saturating counter report the loss.
module verdict_collector #(
  parameter int NUM_OUTPUTS = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int TS_WIDTH    = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0]            out_aktv,
  output logic                              rec_valid,
  input  logic                              rec_ready,
  output logic [TS_WIDTH-1:0]               rec_timestamp,
  output logic [NUM_OUTPUTS-1:0]            rec_aktv,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] rec_data,
  output logic [$clog2(DEPTH):0]            fifo_level,
  output logic                              overflow,
  output logic [CNT_WIDTH-1:0]              dropped_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int DW    = NUM_OUTPUTS * DATA_WIDTH;
  localparam int REC_W = TS_WIDTH + NUM_OUTPUTS + DW;

  // Each stored record is packed as {timestamp, activation mask, values}.
  logic [REC_W-1:0]     mem [DEPTH];

  logic [TS_WIDTH-1:0]  ts_reg;
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        level_reg;
  logic                 overflow_reg;
  logic [CNT_WIDTH-1:0] dropped_reg;
  logic [REC_W-1:0]     head_reg;

  logic                 capture;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [PW-1:0]        rd_ptr_next;
  logic [PW-1:0]        wr_ptr_next;
  logic [LW-1:0]        level_next;
  logic [REC_W-1:0]     wr_rec;

  // Capture/push/pop decisions and the next FIFO pointers and level.
  // A pop frees a slot in the same cycle, so a capture while full is still
  // accepted whenever the consumer takes the head at that edge.
  always_comb begin
    capture     = en && (|out_aktv);
    full        = (level_reg == LW'(DEPTH));
    pop         = (level_reg != '0) && rec_ready;
    push        = capture && (!full || pop);
    drop        = capture && full && !pop;
    wr_rec      = {ts_reg, out_aktv, out_data};
    rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    level_next  = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Free-running capture timestamp; advances only while enabled and wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg <= '0;
    end else if (en) begin
      ts_reg <= ts_reg + TS_WIDTH'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Record storage: plain write port, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= wr_rec;
    end
  end

  // Registered head-of-queue read. The address is the read pointer as it will
  // be after this edge. When the slot written this cycle becomes the head
  // (FIFO empty, or down to its last entry being popped), the write data is
  // forwarded because the array still holds the old contents at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= wr_rec;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  // Loss reporting: sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      dropped_reg  <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (dropped_reg != '1) begin
        dropped_reg <= dropped_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign rec_valid     = (level_reg != '0);
  assign fifo_level    = level_reg;
  assign overflow      = overflow_reg;
  assign dropped_count = dropped_reg;
  assign rec_timestamp = head_reg[REC_W-1 -: TS_WIDTH];
  assign rec_aktv      = head_reg[DW +: NUM_OUTPUTS];

  // Unpack the head record's values stream by stream.
  generate
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_stream
      assign rec_data[gi*DATA_WIDTH +: DATA_WIDTH] = head_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

endmodule
